// File: rtl/pool_ctrl.sv
// Sequencer for the 2x2 max-pooling datapath: walks a square feature map in
// non-overlapping 2x2 windows, one window per cycle, and tracks the pool pipeline.
module pool_ctrl #(
  parameter int SWIDTH = 8,
  parameter int AWIDTH = 16
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              req,
  input  logic [SWIDTH-1:0] in_size,
  input  logic [AWIDTH-1:0] in_base,
  input  logic [AWIDTH-1:0] out_base,
  output logic              busy,
  output logic              ack,
  output logic              feat_rd_en,
  output logic [AWIDTH-1:0] feat_addr0,
  output logic [AWIDTH-1:0] feat_addr1,
  output logic [AWIDTH-1:0] feat_addr2,
  output logic [AWIDTH-1:0] feat_addr3,
  output logic              out_en,
  output logic              pmap_we,
  output logic [AWIDTH-1:0] pmap_addr
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [SWIDTH-1:0] ONE_S = SWIDTH'(1);
  localparam logic [AWIDTH-1:0] ONE_A = AWIDTH'(1);
  localparam logic [AWIDTH-1:0] TWO_A = AWIDTH'(2);

  state_t            state, state_nxt;
  logic [SWIDTH-1:0] size_q, size_nxt, wo_q, wo_nxt;
  logic [SWIDTH-1:0] i_q, i_nxt, j_q, j_nxt;
  logic [AWIDTH-1:0] row_q, row_nxt, oa_q, oa_nxt;
  logic [AWIDTH-1:0] a0_nxt, a1_nxt, a2_nxt, a3_nxt;
  logic [AWIDTH-1:0] oa1_q, oa2_q, w2_q;
  logic              busy_nxt, ack_nxt, rd_nxt, vld0_q;

  // Row pointer advances by two input rows at each row end.
  assign w2_q = AWIDTH'(size_q) << 1;

  always_comb begin
    state_nxt = state;
    size_nxt  = size_q;
    wo_nxt    = wo_q;
    i_nxt     = i_q;
    j_nxt     = j_q;
    row_nxt   = row_q;
    oa_nxt    = oa_q;
    a0_nxt    = '0;
    busy_nxt  = 1'b0;
    ack_nxt   = 1'b0;
    rd_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          size_nxt = in_size;
          wo_nxt   = in_size >> 1;
          i_nxt    = '0;
          j_nxt    = '0;
          row_nxt  = in_base;
          oa_nxt   = out_base;
          busy_nxt = 1'b1;
          if (in_size[SWIDTH-1:1] != '0) begin
            state_nxt = S_ISSUE;
            rd_nxt    = 1'b1;
            a0_nxt    = in_base;
          end else begin
            state_nxt = S_DONE;
            ack_nxt   = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        busy_nxt = 1'b1;
        if (j_q != wo_q - ONE_S) begin
          j_nxt  = j_q + ONE_S;
          a0_nxt = feat_addr0 + TWO_A;
          oa_nxt = oa_q + ONE_A;
          rd_nxt = 1'b1;
        end else if (i_q != wo_q - ONE_S) begin
          j_nxt   = '0;
          i_nxt   = i_q + ONE_S;
          row_nxt = row_q + w2_q;
          a0_nxt  = row_q + w2_q;
          oa_nxt  = oa_q + ONE_A;
          rd_nxt  = 1'b1;
        end else begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy_nxt = 1'b1;
        // Only the final pmap_we remains in flight once stages 1 and 2 are empty.
        if (!vld0_q && !out_en) begin
          state_nxt = S_DONE;
          ack_nxt   = 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    a1_nxt = '0;
    a2_nxt = '0;
    a3_nxt = '0;
    if (rd_nxt) begin
      a1_nxt = a0_nxt + ONE_A;
      a2_nxt = a0_nxt + AWIDTH'(size_nxt);
      a3_nxt = a0_nxt + AWIDTH'(size_nxt) + ONE_A;
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state      <= S_IDLE;
      size_q     <= '0;
      wo_q       <= '0;
      i_q        <= '0;
      j_q        <= '0;
      row_q      <= '0;
      oa_q       <= '0;
      busy       <= 1'b0;
      ack        <= 1'b0;
      feat_rd_en <= 1'b0;
      feat_addr0 <= '0;
      feat_addr1 <= '0;
      feat_addr2 <= '0;
      feat_addr3 <= '0;
    end else begin
      state      <= state_nxt;
      size_q     <= size_nxt;
      wo_q       <= wo_nxt;
      i_q        <= i_nxt;
      j_q        <= j_nxt;
      row_q      <= row_nxt;
      oa_q       <= oa_nxt;
      busy       <= busy_nxt;
      ack        <= ack_nxt;
      feat_rd_en <= rd_nxt;
      feat_addr0 <= a0_nxt;
      feat_addr1 <= a1_nxt;
      feat_addr2 <= a2_nxt;
      feat_addr3 <= a3_nxt;
    end
  end

  // Valid chain: read issued (t) -> data at pool (t+1) -> out_en (t+2) -> write (t+3).
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      vld0_q    <= 1'b0;
      out_en    <= 1'b0;
      pmap_we   <= 1'b0;
      oa1_q     <= '0;
      oa2_q     <= '0;
      pmap_addr <= '0;
    end else begin
      vld0_q    <= feat_rd_en;
      out_en    <= vld0_q;
      pmap_we   <= out_en;
      oa1_q     <= feat_rd_en ? oa_q : '0;
      oa2_q     <= oa1_q;
      pmap_addr <= out_en ? oa2_q : '0;
    end
  end

endmodule

// File: tb/tb_pool_ctrl.sv
// Directed bench for pool_ctrl: address/timing tables per job, a small feature
// buffer plus max-pool model for the datapath-coupled case.
module tb_pool_ctrl;
  localparam int SW = 8;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          xrst = 1'b0;
  logic          req = 1'b0;
  logic [SW-1:0] in_size = '0;
  logic [AW-1:0] in_base = '0, out_base = '0;
  logic          busy, ack, feat_rd_en, out_en, pmap_we;
  logic [AW-1:0] feat_addr0, feat_addr1, feat_addr2, feat_addr3, pmap_addr;
  logic [84:0]   all_out;

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] exp_q[$];

  // per-cycle capture of one job, index = cycles after the req cycle
  logic          r_rd [0:39], r_oe [0:39], r_we [0:39], r_busy [0:39], r_ack [0:39];
  logic [AW-1:0] r_a0 [0:39], r_a1 [0:39], r_a2 [0:39], r_a3 [0:39], r_pa [0:39];
  logic [7:0]    r_res [0:39];

  // feature buffer (1-cycle read), pool input register, out_en-gated result
  logic signed [7:0] mem [0:15];
  logic signed [7:0] p0, p1, p2, p3, q0, q1, q2, q3, pool_res;

  pool_ctrl #(.SWIDTH(SW), .AWIDTH(AW)) dut (
    .clk(clk), .xrst(xrst), .req(req), .in_size(in_size), .in_base(in_base),
    .out_base(out_base), .busy(busy), .ack(ack), .feat_rd_en(feat_rd_en),
    .feat_addr0(feat_addr0), .feat_addr1(feat_addr1), .feat_addr2(feat_addr2),
    .feat_addr3(feat_addr3), .out_en(out_en), .pmap_we(pmap_we), .pmap_addr(pmap_addr)
  );

  assign all_out = {busy, ack, feat_rd_en, feat_addr0, feat_addr1, feat_addr2,
                    feat_addr3, out_en, pmap_we, pmap_addr};

  always #5 clk = ~clk;

  function automatic logic signed [7:0] max4(input logic signed [7:0] a, b, c, d);
    logic signed [7:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  always @(posedge clk) begin
    if (feat_rd_en) begin
      p0 <= mem[feat_addr0[3:0]];
      p1 <= mem[feat_addr1[3:0]];
      p2 <= mem[feat_addr2[3:0]];
      p3 <= mem[feat_addr3[3:0]];
    end
    q0 <= p0; q1 <= p1; q2 <= p2; q3 <= p3;
    if (out_en) pool_res <= max4(q0, q1, q2, q3);
  end

  // Drives one req (cycle 0) and records outputs at mid-cycle for cycles 1..ncyc.
  // req stays high for cycles < req_cycles and is also raised in cycle pulse_at.
  task automatic run_job(input logic [SW-1:0] w, input logic [AW-1:0] ib, ob,
                         input int ncyc, input int req_cycles, input int pulse_at);
    @(negedge clk);
    in_size = w; in_base = ib; out_base = ob; req = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      r_rd[c] = feat_rd_en; r_oe[c] = out_en; r_we[c] = pmap_we;
      r_busy[c] = busy; r_ack[c] = ack; r_pa[c] = pmap_addr;
      r_a0[c] = feat_addr0; r_a1[c] = feat_addr1; r_a2[c] = feat_addr2; r_a3[c] = feat_addr3;
      r_res[c] = pool_res;
      req = (c < req_cycles) || (c == pulse_at);
      if (c == 1) begin in_size = ~w; in_base = ~ib; out_base = ~ob; end
    end
    req = 1'b0;
  endtask

  task automatic test_reset();
    xrst = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_async: got %h expected 0", all_out); end
    repeat (2) @(negedge clk);
    xrst = 1'b1;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_idle: got %h expected 0", all_out); end
  endtask

  task automatic test_reset_mid_job();
    int n_ack, n_we;
    run_job(8'd8, 16'h0000, 16'h1000, 5, 1, -1);
    checks++;
    if (r_rd[5] !== 1'b1) begin errors++; $display("FAIL midjob_issuing: got %b expected 1", r_rd[5]); end
    #2 xrst = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL midjob_reset_outputs: got %h expected 0", all_out); end
    @(negedge clk);
    xrst = 1'b1;
    n_ack = 0; n_we = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (ack) n_ack++;
      if (pmap_we) n_we++;
    end
    checks++;
    if (n_ack != 0) begin errors++; $display("FAIL midjob_no_ack: got %0d acks expected 0", n_ack); end
    checks++;
    if (n_we != 0) begin errors++; $display("FAIL midjob_no_we: got %0d writes expected 0", n_we); end
  endtask

  task automatic test_w4();
    logic [AW-1:0] tab [4];
    logic [AW-1:0] got;
    tab[0] = 16'h100; tab[1] = 16'h102; tab[2] = 16'h108; tab[3] = 16'h10A;
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(16'h200 + AW'(k));
    run_job(8'd4, 16'h0100, 16'h0200, 12, 1, -1);
    for (int c = 1; c <= 12; c++) begin
      checks++;
      if (r_rd[c] !== (c <= 4)) begin errors++; $display("FAIL w4_rd cycle %0d: got %b expected %b", c, r_rd[c], c <= 4); end
      if (c <= 4) begin
        checks++;
        if (r_a0[c] !== tab[c-1]) begin errors++; $display("FAIL w4_addr0 cycle %0d: got %h expected %h", c, r_a0[c], tab[c-1]); end
      end
      checks++;
      if (r_oe[c] !== (c >= 3 && c <= 6)) begin errors++; $display("FAIL w4_out_en cycle %0d: got %b", c, r_oe[c]); end
      checks++;
      if (r_we[c] !== (c >= 4 && c <= 7)) begin errors++; $display("FAIL w4_we cycle %0d: got %b", c, r_we[c]); end
      if (r_we[c] === 1'b1 && exp_q.size() > 0) begin
        got = exp_q.pop_front();
        checks++;
        if (r_pa[c] !== got) begin errors++; $display("FAIL w4_pmap_addr cycle %0d: got %h expected %h", c, r_pa[c], got); end
      end
      checks++;
      if (r_ack[c] !== (c == 8)) begin errors++; $display("FAIL w4_ack cycle %0d: got %b expected %b", c, r_ack[c], c == 8); end
      checks++;
      if (r_busy[c] !== (c <= 8)) begin errors++; $display("FAIL w4_busy cycle %0d: got %b expected %b", c, r_busy[c], c <= 8); end
    end
    checks++;
    if ({r_a1[1], r_a2[1], r_a3[1]} !== {16'h101, 16'h104, 16'h105}) begin
      errors++; $display("FAIL w4_first_window: got %h %h %h expected 101 104 105", r_a1[1], r_a2[1], r_a3[1]);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL w4_writes_missing: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_datapath();
    int rd_c, oe_c, n_we, we_c;
    for (int k = 0; k < 16; k++) mem[k] = 8'sd0;
    mem[0] = 8'sd3; mem[1] = -8'sd7; mem[2] = 8'sd9; mem[3] = 8'sd1;
    run_job(8'd2, 16'h0000, 16'h0030, 8, 1, -1);
    rd_c = -1; oe_c = -1; we_c = -1; n_we = 0;
    for (int c = 1; c <= 8; c++) begin
      if (r_rd[c] && rd_c < 0) rd_c = c;
      if (r_oe[c] && oe_c < 0) oe_c = c;
      if (r_we[c]) begin n_we++; we_c = c; end
    end
    checks++;
    if (rd_c != 1 || oe_c - rd_c != 2) begin errors++; $display("FAIL dp_out_en_lag: rd %0d out_en %0d expected 1 and 3", rd_c, oe_c); end
    checks++;
    if (n_we != 1) begin errors++; $display("FAIL dp_write_count: got %0d expected 1", n_we); end
    if (we_c > 0) begin
      checks++;
      if (r_res[we_c] !== 8'd9 || r_pa[we_c] !== 16'h30) begin
        errors++; $display("FAIL dp_result: got %0d at %h expected 9 at 0030", $signed(r_res[we_c]), r_pa[we_c]);
      end
    end
    checks++;
    if (r_ack[5] !== 1'b1) begin errors++; $display("FAIL dp_ack: got %b expected 1 in cycle 5", r_ack[5]); end
  endtask

  task automatic test_odd();
    logic [AW-1:0] tab [4];
    int n_we;
    tab[0] = 16'h40; tab[1] = 16'h42; tab[2] = 16'h4A; tab[3] = 16'h4C;
    run_job(8'd5, 16'h0040, 16'h0080, 10, 1, -1);
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (r_rd[c] !== 1'b1 || r_a0[c] !== tab[c-1]) begin
        errors++; $display("FAIL w5_addr0 cycle %0d: got %b/%h expected 1/%h", c, r_rd[c], r_a0[c], tab[c-1]);
      end
    end
    checks++;
    if (r_a3[4] !== 16'h52) begin errors++; $display("FAIL w5_last_addr3: got %h expected 0052", r_a3[4]); end
    n_we = 0;
    for (int c = 1; c <= 10; c++) if (r_we[c]) n_we++;
    checks++;
    if (n_we != 4 || r_rd[5] !== 1'b0) begin errors++; $display("FAIL w5_counts: writes %0d rd5 %b expected 4 and 0", n_we, r_rd[5]); end
    checks++;
    if (r_pa[7] !== 16'h83 || r_ack[8] !== 1'b1) begin errors++; $display("FAIL w5_tail: pa %h ack %b expected 0083 1", r_pa[7], r_ack[8]); end
  endtask

  task automatic test_tiny(input logic [SW-1:0] w);
    int n_rd, n_we, n_ack;
    run_job(w, 16'h0010, 16'h0020, 6, 1, -1);
    n_rd = 0; n_we = 0; n_ack = 0;
    for (int c = 1; c <= 6; c++) begin
      if (r_rd[c]) n_rd++;
      if (r_we[c]) n_we++;
      if (r_ack[c]) n_ack++;
    end
    checks++;
    if (r_ack[1] !== 1'b1 || n_ack != 1) begin errors++; $display("FAIL tiny_ack W=%0d: ack1 %b count %0d expected 1 1", w, r_ack[1], n_ack); end
    checks++;
    if (n_rd != 0 || n_we != 0) begin errors++; $display("FAIL tiny_no_access W=%0d: rd %0d we %0d expected 0 0", w, n_rd, n_we); end
    checks++;
    if (r_busy[1] !== 1'b1 || r_busy[2] !== 1'b0) begin errors++; $display("FAIL tiny_busy W=%0d: got %b%b expected 10", w, r_busy[1], r_busy[2]); end
  endtask

  task automatic test_back_to_back(input int req_cycles, input int pulse_at);
    int n_rd, n_ack, n_busy_late;
    run_job(8'd4, 16'h0100, 16'h0200, 16, req_cycles, pulse_at);
    n_rd = 0; n_ack = 0; n_busy_late = 0;
    for (int c = 1; c <= 16; c++) begin
      if (r_rd[c]) n_rd++;
      if (r_ack[c]) n_ack++;
      if (c >= 9 && r_busy[c]) n_busy_late++;
    end
    checks++;
    if (n_rd != 4 || n_ack != 1 || r_ack[8] !== 1'b1) begin
      errors++; $display("FAIL b2b_single_job: rd %0d ack %0d ack8 %b expected 4 1 1", n_rd, n_ack, r_ack[8]);
    end
    checks++;
    if (n_busy_late != 0) begin errors++; $display("FAIL b2b_no_restart: busy cycles %0d expected 0", n_busy_late); end
    run_job(8'd2, 16'h0000, 16'h0000, 6, 1, -1);
    checks++;
    if (r_rd[1] !== 1'b1 || r_ack[5] !== 1'b1) begin errors++; $display("FAIL b2b_next_job: rd1 %b ack5 %b expected 1 1", r_rd[1], r_ack[5]); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_job();
    test_w4();
    test_datapath();
    test_odd();
    test_tiny(8'd1);
    test_tiny(8'd0);
    test_back_to_back(9, -1);
    test_back_to_back(1, 8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
